// File: rtl/hazard_stall_scheduler.sv
// Pipeline hazard / stall scheduler: load-use bubbles, multi-cycle MDU sequencing,
// data-memory wait states and taken-branch flush ordering for a 5-stage pipe.
module hazard_stall_scheduler #(
  parameter int REG_AW      = 5,
  parameter int MDU_LAT     = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              id_mdu_op,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              branch_taken,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              stall,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              mdu_busy,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int MDU_CW = $clog2(MDU_LAT + 1);
  localparam int MEM_CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [MDU_CW-1:0] MDU_INIT = MDU_CW'(MDU_LAT - 1);
  localparam logic [MDU_CW-1:0] MDU_ONE  = MDU_CW'(1);
  localparam logic [MEM_CW-1:0] MEM_ONE  = MEM_CW'(1);
  localparam logic [MEM_CW-1:0] MEM_MAX  = MEM_CW'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CYC_ONE  = CNT_W'(1);
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {ST_RUN, ST_MDU, ST_MEM} state_t;

  state_t             state_q, state_d;
  logic [MDU_CW-1:0]  mdu_cnt_q, mdu_cnt_d;
  logic [MEM_CW-1:0]  mem_cnt_q, mem_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

  logic mem_hold;
  logic load_use;
  logic hold;
  logic stall_raw;
  logic flush_if_id_raw;
  logic flush_id_ex_raw;

  always_comb begin
    mem_hold = dmem_req & ~dmem_ready;
    load_use = ex_mem_read & (ex_rd != REG_ZERO) &
               ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
    hold     = mem_hold | (state_q == ST_MDU);

    // A frozen pipe keeps a taken branch parked in EX, so its flush waits for hold to drop.
    stall_raw       = 1'b0;
    flush_if_id_raw = 1'b0;
    flush_id_ex_raw = 1'b0;
    if (hold) begin
      stall_raw = 1'b1;
    end else if (branch_taken) begin
      flush_if_id_raw = 1'b1;
      flush_id_ex_raw = 1'b1;
    end else if (load_use) begin
      stall_raw       = 1'b1;
      flush_id_ex_raw = 1'b1;
    end
  end

  assign stall        = rst_n & stall_raw;
  assign flush_if_id  = rst_n & flush_if_id_raw;
  assign flush_id_ex  = rst_n & flush_id_ex_raw;
  assign mdu_busy     = rst_n & (state_q == ST_MDU);
  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;

  always_comb begin
    state_d        = state_q;
    mdu_cnt_d      = mdu_cnt_q;
    mem_cnt_d      = mem_cnt_q;
    mem_timeout_d  = mem_timeout_q | (mem_cnt_q == MEM_MAX);
    stall_cycles_d = stall_cycles_q;
    if (stall_raw && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CYC_ONE;
    end

    case (state_q)
      ST_RUN: begin
        if (mem_hold) begin
          state_d   = ST_MEM;
          mem_cnt_d = MEM_ONE;
        end else if (id_mdu_op && !branch_taken && !load_use) begin
          state_d   = ST_MDU;
          mdu_cnt_d = MDU_INIT;
        end
      end
      ST_MDU: begin
        // A memory wait arriving here only adds to stall; the countdown keeps running.
        mdu_cnt_d = mdu_cnt_q - MDU_ONE;
        if (mdu_cnt_q == MDU_ONE) begin
          state_d = ST_RUN;
        end
      end
      ST_MEM: begin
        if (dmem_ready) begin
          state_d   = ST_RUN;
          mem_cnt_d = '0;
        end else if (mem_cnt_q != MEM_MAX) begin
          mem_cnt_d = mem_cnt_q + MEM_ONE;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      mdu_cnt_q      <= '0;
      mem_cnt_q      <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      mdu_cnt_q      <= mdu_cnt_d;
      mem_cnt_q      <= mem_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_scheduler.sv
// Directed bench for hazard_stall_scheduler: hand-computed expectations checked
// with immediate assertions along one linear stimulus sequence.
module tb_hazard_stall_scheduler;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, id_mdu_op, ex_mem_read;
  logic        branch_taken, dmem_req, dmem_ready;
  logic        stall, flush_if_id, flush_id_ex, mdu_busy, mem_timeout;
  logic [15:0] stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_stall_scheduler #(
    .REG_AW(5), .MDU_LAT(4), .MEM_TIMEOUT(15), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_mdu_op(id_mdu_op), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .mdu_busy(mdu_busy), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of sequence");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic s, input logic fi, input logic fe);
    #1;
    chk({tag, "_stall"}, {31'd0, stall}, {31'd0, s});
    chk({tag, "_flush_if_id"}, {31'd0, flush_if_id}, {31'd0, fi});
    chk({tag, "_flush_id_ex"}, {31'd0, flush_id_ex}, {31'd0, fe});
  endtask

  task automatic clear_in();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_rs1_used = 0; id_rs2_used = 0; id_mdu_op = 0; ex_mem_read = 0;
    branch_taken = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  initial begin
    clear_in();
    rst_n = 0;
    tick(); tick();
    chk_out("reset", 0, 0, 0);
    chk("reset_busy", {31'd0, mdu_busy}, 32'd0);
    chk("reset_timeout", {31'd0, mem_timeout}, 32'd0);
    chk("reset_cycles", {16'd0, stall_cycles}, 32'd0);
    dmem_req = 1;
    chk_out("reset_forced", 0, 0, 0);
    dmem_req = 0;
    rst_n = 1;
    tick();

    // load x5, ID reads rs2=x5
    ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_rs2_used = 1;
    chk_out("load_use_rs2", 1, 0, 1);
    tick();
    clear_in();
    chk_out("load_use_clear", 0, 0, 0);
    chk("load_use_cycles", {16'd0, stall_cycles}, 32'd1);

    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1;
    chk_out("rd_zero", 0, 0, 0);
    ex_rd = 7; id_rs1 = 7; id_rs1_used = 0;
    chk_out("rs1_unused", 0, 0, 0);
    id_rs1_used = 1;
    chk_out("load_use_rs1", 1, 0, 1);
    ex_rd = 3; id_rs1 = 3; branch_taken = 1;
    chk_out("branch_vs_load_use", 0, 1, 1);
    clear_in();
    #1;

    // MDU op issue then 3 stall cycles
    id_mdu_op = 1;
    chk_out("mdu_issue", 0, 0, 0);
    tick();
    id_mdu_op = 0;
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("mdu_hold%0d", i), 1, 0, 0);
      chk($sformatf("mdu_busy%0d", i), {31'd0, mdu_busy}, 32'd1);
      tick();
    end
    chk_out("mdu_done", 0, 0, 0);
    chk("mdu_done_busy", {31'd0, mdu_busy}, 32'd0);
    chk("mdu_cycles", {16'd0, stall_cycles}, 32'd4);

    // memory wait of 20 cycles, with a branch parked during the hold
    dmem_req = 1; dmem_ready = 0;
    chk_out("mem_hold", 1, 0, 0);
    repeat (14) tick();
    chk("mem_timeout_early", {31'd0, mem_timeout}, 32'd0);
    branch_taken = 1;
    chk_out("branch_during_hold", 1, 0, 0);
    chk("mem_no_busy", {31'd0, mdu_busy}, 32'd0);
    repeat (6) tick();
    chk("mem_timeout_set", {31'd0, mem_timeout}, 32'd1);
    chk_out("mem_hold20", 1, 0, 0);
    dmem_ready = 1;
    chk_out("branch_deferred", 0, 1, 1);
    tick();
    clear_in();
    chk_out("mem_done", 0, 0, 0);
    chk("mem_timeout_sticky", {31'd0, mem_timeout}, 32'd1);
    chk("mem_cycles", {16'd0, stall_cycles}, 32'd24);

    // reset in the middle of an MDU countdown
    id_mdu_op = 1;
    tick();
    id_mdu_op = 0;
    tick();
    chk("mdu_mid_busy", {31'd0, mdu_busy}, 32'd1);
    rst_n = 0;
    chk_out("mdu_rst_forced", 0, 0, 0);
    tick();
    rst_n = 1;
    chk_out("post_rst", 0, 0, 0);
    chk("post_rst_busy", {31'd0, mdu_busy}, 32'd0);
    chk("post_rst_timeout", {31'd0, mem_timeout}, 32'd0);
    chk("post_rst_cycles", {16'd0, stall_cycles}, 32'd0);
    tick();
    chk_out("post_rst_no_residual", 0, 0, 0);
    chk("post_rst_busy2", {31'd0, mdu_busy}, 32'd0);

    // stall counter saturation
    dmem_req = 1; dmem_ready = 0;
    repeat (65534) tick();
    chk("cycles_pre_sat", {16'd0, stall_cycles}, 32'h0000_FFFE);
    tick();
    chk("cycles_sat", {16'd0, stall_cycles}, 32'h0000_FFFF);
    repeat (4) tick();
    chk("cycles_hold_sat", {16'd0, stall_cycles}, 32'h0000_FFFF);
    clear_in();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
